// File: rtl/divider_pkg.sv
// Shared constants for the 8-bit sequential restoring divider tile:
// FSM encoding, uio bit positions, output-enable mask and iteration count.
package divider_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int START = 0;
   localparam int LD_B  = 1;
   localparam int SEL   = 2;
   localparam int BUSY  = 6;
   localparam int DONE  = 7;

   localparam logic [7:0] UIO_OE_MASK = 8'hC0;
   localparam int         N           = 8;
endpackage

// File: rtl/tt_um_8bit_divider_if.sv
// Tile-side byte bus of the divider: operand/control in, result/status out.
interface tt_um_8bit_divider_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/rsub9.sv
// 9-bit ripple-borrow subtractor (a - b), one full-subtractor cell per bit,
// same ripple shape as the companion adder tile.
module rsub9 (
   input  logic [8:0] a,
   input  logic [8:0] b,
   output logic [8:0] diff,
   output logic       borrow
);
   logic [9:0] bw;

   assign bw[0] = 1'b0;

   for (genvar gi = 0; gi < 9; gi++) begin : g_cell
      assign diff[gi]  = a[gi] ^ b[gi] ^ bw[gi];
      assign bw[gi+1]  = (~a[gi] & (b[gi] | bw[gi])) | (b[gi] & bw[gi]);
   end

   assign borrow = bw[9];
endmodule

// File: rtl/tt_um_8bit_divider.sv
// Sequential 8-bit unsigned restoring divider in the TinyTapeout tile wrapper;
// one quotient bit per clock, result selected onto uo_out by sel.
module tt_um_8bit_divider
   import divider_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [1:0] state;
   logic [7:0] b_r, q_r, r_r;
   logic [2:0] cnt;
   logic [8:0] t, d;
   logic       bw;

   logic start, ld_b, sel;
   assign start = uio_in[START];
   assign ld_b  = uio_in[LD_B];
   assign sel   = uio_in[SEL];

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   assign t = {r_r, q_r[7]};

   rsub9 u_sub (
      .a      (t),
      .b      ({1'b0, b_r}),
      .diff   (d),
      .borrow (bw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         b_r   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (bw) begin
                  r_r <= t[7:0];
                  q_r <= {q_r[6:0], 1'b0};
               end else begin
                  r_r <= d[7:0];
                  q_r <= {q_r[6:0], 1'b1};
               end
               cnt <= cnt + 3'd1;
               if (cnt == 3'(N - 1)) state <= ST_DONE;
            end
            default: begin
               if (ld_b) b_r <= ui_in;
               if (start) begin
                  q_r   <= ui_in;
                  r_r   <= '0;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
         endcase
      end
   end

   always_comb begin
      uio_out       = '0;
      uio_out[BUSY] = (state == ST_RUN);
      uio_out[DONE] = (state == ST_DONE);
   end

   assign uio_oe = UIO_OE_MASK;
   assign uo_out = sel ? r_r : q_r;

   // d[8] is always clear when no borrow occurs, since R < B holds throughout.
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:3], d[8]};
endmodule

// File: tb/tb_tt_um_8bit_divider.sv
// Self-checking bench for tt_um_8bit_divider: directed scenarios plus random
// operands compared against plain-arithmetic quotient/remainder.
module tb_tt_um_8bit_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   tt_um_8bit_divider_if bus ();

   tt_um_8bit_divider dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (bus.ui_in),
      .uio_in  (bus.uio_in),
      .uo_out  (bus.uo_out),
      .uio_out (bus.uio_out),
      .uio_oe  (bus.uio_oe)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
      return (b == 0) ? 8'hFF : 8'(a / b);
   endfunction

   function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
      return (b == 0) ? a : 8'(a % b);
   endfunction

   task automatic drive(input logic st, input logic ld, input logic sl, input logic [7:0] ui);
      bus.uio_in = {5'b0, sl, ld, st};
      bus.ui_in  = ui;
   endtask

   task automatic load_b(input logic [7:0] b);
      @(negedge clk); drive(1'b0, 1'b1, 1'b0, b);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Returns at the negedge right after the start-capturing edge.
   task automatic start_op(input logic [7:0] a);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, a);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Counts busy cycles until busy drops, bounded.
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (bus.uio_out[6] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic read_res(output logic [7:0] q, output logic [7:0] r);
      bus.uio_in[2] = 1'b0; #1; q = bus.uo_out;
      bus.uio_in[2] = 1'b1; #1; r = bus.uo_out;
      bus.uio_in[2] = 1'b0; #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      #2;
      n_checks++;
      if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", bus.uo_out); end
      n_checks++;
      if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", bus.uio_out); end
      n_checks++;
      if (bus.uio_oe !== 8'hC0) begin n_fail++; $display("FAIL uio_oe: got %h want c0", bus.uio_oe); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL idle_status: got %h want 00", bus.uio_out); end
   endtask

   task automatic test_basic();
      int cyc;
      logic [7:0] q, r;
      load_b(8'd7);
      start_op(8'd100);
      n_checks++;
      if (bus.uio_out !== 8'h40) begin n_fail++; $display("FAIL basic_busy_after_e0: got %h want 40", bus.uio_out); end
      wait_idle(cyc);
      n_checks++;
      if (cyc !== 8) begin n_fail++; $display("FAIL basic_busy_len: got %0d want 8", cyc); end
      n_checks++;
      if (bus.uio_out !== 8'h80) begin n_fail++; $display("FAIL basic_done: got %h want 80", bus.uio_out); end
      read_res(q, r);
      n_checks++;
      if (q !== 8'h0E) begin n_fail++; $display("FAIL basic_q: got %h want 0e", q); end
      n_checks++;
      if (r !== 8'h02) begin n_fail++; $display("FAIL basic_r: got %h want 02", r); end
      repeat (3) @(negedge clk);
      read_res(q, r);
      n_checks++;
      if (bus.uio_out !== 8'h80 || q !== 8'h0E || r !== 8'h02) begin
         n_fail++; $display("FAIL basic_hold: got status %h q %h r %h want 80 0e 02", bus.uio_out, q, r);
      end
   endtask

   task automatic test_edges();
      int cyc;
      logic [7:0] q, r;
      logic [7:0] av [3] = '{8'hFF, 8'h05, 8'h3C};
      logic [7:0] bv [3] = '{8'h01, 8'h09, 8'h00};
      logic [7:0] eq [3] = '{8'hFF, 8'h00, 8'hFF};
      logic [7:0] er [3] = '{8'h00, 8'h05, 8'h3C};
      for (int i = 0; i < 3; i++) begin
         load_b(bv[i]);
         start_op(av[i]);
         wait_idle(cyc);
         n_checks++;
         if (cyc !== 8 || bus.uio_out !== 8'h80) begin
            n_fail++; $display("FAIL edge%0d_timing: got cyc %0d status %h want 8 80", i, cyc, bus.uio_out);
         end
         read_res(q, r);
         n_checks++;
         if (q !== eq[i] || r !== er[i]) begin
            n_fail++; $display("FAIL edge%0d_result: got q %h r %h want q %h r %h", i, q, r, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_run_ignore();
      int cyc;
      logic [7:0] q, r;
      load_b(8'd3);
      start_op(8'd200);
      repeat (3) @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 8'h11);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (bus.uio_out !== 8'h40) begin n_fail++; $display("FAIL ignore_busy: got %h want 40", bus.uio_out); end
      wait_idle(cyc);
      n_checks++;
      if (cyc !== 4) begin n_fail++; $display("FAIL ignore_len: got %0d want 4", cyc); end
      read_res(q, r);
      n_checks++;
      if (q !== 8'h42 || r !== 8'h02) begin n_fail++; $display("FAIL ignore_result: got q %h r %h want 42 02", q, r); end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      logic [7:0] q, r;
      load_b(8'd7);
      start_op(8'd100);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL midrst_status: got %h want 00", bus.uio_out); end
      read_res(q, r);
      n_checks++;
      if (q !== 8'h00 || r !== 8'h00) begin n_fail++; $display("FAIL midrst_regs: got q %h r %h want 00 00", q, r); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL midrst_idle: got %h want 00", bus.uio_out); end
      // B must be cleared: dividing without a reload behaves as divide-by-zero.
      start_op(8'h3C);
      wait_idle(cyc);
      read_res(q, r);
      n_checks++;
      if (q !== 8'hFF || r !== 8'h3C) begin n_fail++; $display("FAIL midrst_b_cleared: got q %h r %h want ff 3c", q, r); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [7:0] q, r;
      load_b(8'h10);
      start_op(8'h35);
      wait_idle(cyc);
      // First DONE cycle: restart immediately with B still 0x10.
      drive(1'b1, 1'b0, 1'b0, 8'h80);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (bus.uio_out !== 8'h40) begin n_fail++; $display("FAIL b2b_done_falls: got %h want 40", bus.uio_out); end
      wait_idle(cyc);
      read_res(q, r);
      n_checks++;
      if (cyc !== 8 || q !== 8'h08 || r !== 8'h00) begin
         n_fail++; $display("FAIL b2b_result: got cyc %0d q %h r %h want 8 08 00", cyc, q, r);
      end
      // start and ld_b together on the first DONE cycle latch the same byte.
      drive(1'b1, 1'b1, 1'b0, 8'h80);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 8'h00);
      wait_idle(cyc);
      read_res(q, r);
      n_checks++;
      if (q !== 8'h01 || r !== 8'h00) begin n_fail++; $display("FAIL b2b_same_byte: got q %h r %h want 01 00", q, r); end
   endtask

   task automatic test_random();
      int cyc;
      logic [7:0] a, b, q, r;
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 6 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         if (i % 4 == 3) b = 8'($urandom_range(1, 15));
         load_b(b);
         start_op(a);
         wait_idle(cyc);
         read_res(q, r);
         n_checks++;
         if (cyc !== 8 || q !== ref_q(a, b) || r !== ref_r(a, b)) begin
            n_fail++;
            $display("FAIL rand_%0d %h/%h: got cyc %0d q %h r %h want 8 q %h r %h",
                     i, a, b, cyc, q, r, ref_q(a, b), ref_r(a, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_run_ignore();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
